// File: rtl/if_id_pipe_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
// Also holds the per-edge action decode that fixes the stall/flush priority.
package if_id_pipe_pkg;

    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_FLUSH
    } pipe_act_e;

    // Flush beats any stall; a stalled stage whose successor runs must emit a bubble.
    function automatic pipe_act_e decode_act(
        input logic flush,
        input logic stall_self,
        input logic stall_next
    );
        if (flush)
            return ACT_FLUSH;
        else if (stall_self == STOP && stall_next == NO_STOP)
            return ACT_BUBBLE;
        else if (stall_self == STOP)
            return ACT_HOLD;
        else
            return ACT_ADVANCE;
    endfunction

endpackage

// File: rtl/if_id_pipe_inst_hold_buf.sv
// Capture register that freezes synchronous-IMEM data while the stage is held.
// clr has priority over capture, so a flush or bubble always releases the buffer.
module inst_hold_buf
    import if_id_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             capture,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             vld
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             vld_d, vld_q;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (clr) begin
            vld_d = 1'b0;
        end else if (capture) begin
            data_d = din;
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign dout = data_q;
    assign vld  = vld_q;

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: PC, LANES instruction lanes and per-lane valids into decode.
// Supports synchronous-IMEM passthrough with a hold buffer, or fully registered capture.
module if_id_pipe
    import if_id_pipe_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                INST_W    = 32,
    parameter int                LANES     = 1,
    parameter int                STALL_W   = 6,
    parameter int                STAGE_IDX = 1,
    parameter int                INST_REG  = 0,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         if_pc,
    input  logic [LANES*INST_W-1:0]   if_inst,
    input  logic [LANES-1:0]          if_valid,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    output logic [ADDR_W-1:0]         id_pc,
    output logic [LANES*INST_W-1:0]   id_inst,
    output logic [LANES-1:0]          id_valid,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          bubble_cnt
);

    localparam int LW = LANES * INST_W;

    pipe_act_e         act;
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic [LANES-1:0]  valid_d, valid_q;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0]  bubble_cnt_d, bubble_cnt_q;
    logic [LW-1:0]     raw_inst;
    logic              unused_stall;

    assign act          = decode_act(flush, stall[STAGE_IDX], stall[STAGE_IDX+1]);
    assign unused_stall = ^stall;

    always_comb begin
        pc_d         = pc_q;
        valid_d      = valid_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        case (act)
            ACT_FLUSH, ACT_BUBBLE: begin
                pc_d    = RESET_PC;
                valid_d = '0;
                if (!(&bubble_cnt_q))
                    bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
            ACT_HOLD: begin
                if (!(&stall_cnt_q))
                    stall_cnt_d = stall_cnt_q + 1'b1;
            end
            default: begin
                pc_d    = if_pc;
                valid_d = if_valid;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pc_q         <= RESET_PC;
            valid_q      <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    generate
        if (INST_REG == 0) begin : g_hold
            // IMEM already lags its PC by one cycle; the buffer only keeps
            // decode from seeing the address change made during a hold.
            logic          hold_vld;
            logic          hold_capture;
            logic          hold_clr;
            logic [LW-1:0] hold_dout;

            assign hold_capture = (act == ACT_HOLD) && !hold_vld;
            assign hold_clr     = (act != ACT_HOLD);

            inst_hold_buf #(
                .WIDTH (LW)
            ) u_hold (
                .clk     (clk),
                .rst     (rst),
                .clr     (hold_clr),
                .capture (hold_capture),
                .din     (id_inst),
                .dout    (hold_dout),
                .vld     (hold_vld)
            );

            assign raw_inst = hold_vld ? hold_dout : if_inst;
        end else begin : g_reg
            logic [LW-1:0] inst_d, inst_q;

            always_comb begin
                inst_d = inst_q;
                if (act == ACT_ADVANCE)
                    inst_d = if_inst;
            end

            always_ff @(posedge clk) begin
                if (rst == RST_ENABLE)
                    inst_q <= '0;
                else
                    inst_q <= inst_d;
            end

            assign raw_inst = inst_q;
        end
    endgenerate

    always_comb begin
        id_inst = '0;
        for (int i = 0; i < LANES; i++)
            id_inst[i*INST_W +: INST_W] = raw_inst[i*INST_W +: INST_W] & {INST_W{valid_q[i]}};
    end

    assign id_pc      = pc_q;
    assign id_valid   = valid_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed bench for if_id_pipe: one-lane passthrough, two-lane narrow-counter
// passthrough and one-lane registered variant driven from a shared stall/flush.
module tb_if_id_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [0:0]  if_valid;
    logic [63:0] if_inst1;
    logic [1:0]  if_valid1;
    logic [5:0]  stall;
    logic        flush;

    logic [31:0] id_pc0, id_inst0, id_pc2, id_inst2, id_pc1;
    logic [0:0]  id_valid0, id_valid2;
    logic [15:0] stall_cnt0, bubble_cnt0, stall_cnt2, bubble_cnt2;
    logic [63:0] id_inst1;
    logic [1:0]  id_valid1, stall_cnt1, bubble_cnt1;

    int checks = 0;
    int errors = 0;

    if_id_pipe #(.LANES(1), .INST_REG(0)) dut0 (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
        .stall(stall), .flush(flush), .id_pc(id_pc0), .id_inst(id_inst0),
        .id_valid(id_valid0), .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0)
    );

    if_id_pipe #(.LANES(2), .INST_REG(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst1), .if_valid(if_valid1),
        .stall(stall), .flush(flush), .id_pc(id_pc1), .id_inst(id_inst1),
        .id_valid(id_valid1), .stall_cnt(stall_cnt1), .bubble_cnt(bubble_cnt1)
    );

    if_id_pipe #(.LANES(1), .INST_REG(1)) dut2 (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
        .stall(stall), .flush(flush), .id_pc(id_pc2), .id_inst(id_inst2),
        .id_valid(id_valid2), .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] inst,
                                 input logic valid, input logic [63:0] inst1,
                                 input logic [1:0] valid1, input logic [5:0] stl,
                                 input logic fl);
        if_pc     = pc;
        if_inst   = inst;
        if_valid  = valid;
        if_inst1  = inst1;
        if_valid1 = valid1;
        stall     = stl;
        flush     = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(32'h0, 32'h0, 1'b0, 64'h0, 2'b00, 6'b000000, 1'b0);
        tick();
        tick();
        checkOutput("rst_pc", id_pc0, 64'h0);
        checkOutput("rst_valid", id_valid0, 64'h0);
        checkOutput("rst_inst", id_inst0, 64'h0);
        checkOutput("rst_stall_cnt", stall_cnt0, 64'h0);
        checkOutput("rst_bubble_cnt", bubble_cnt0, 64'h0);
        checkOutput("rst_inst_reg", id_inst2, 64'h0);
        rst = 1'b0;

        $display("[TB] advance");
        applyStimulus(32'h100, 32'h2402000A, 1'b1, {32'h8C430004, 32'h2402000A}, 2'b01, 6'b000000, 1'b0);
        tick();
        checkOutput("adv_pc", id_pc0, 64'h100);
        checkOutput("adv_valid", id_valid0, 64'h1);
        checkOutput("adv_inst", id_inst0, 64'h2402000A);
        checkOutput("adv_inst_reg", id_inst2, 64'h2402000A);
        checkOutput("lane1_masked", id_inst1, 64'h00000000_2402000A);
        checkOutput("lane_valid", id_valid1, 64'h1);

        $display("[TB] hold");
        applyStimulus(32'h104, 32'h2402000A, 1'b1, {32'h8C430004, 32'h2402000A}, 2'b01, 6'b000110, 1'b0);
        tick();
        applyStimulus(32'h104, 32'hDEADBEEF, 1'b1, {32'hDEADBEEF, 32'hDEADBEEF}, 2'b11, 6'b000110, 1'b0);
        checkOutput("hold1_inst", id_inst0, 64'h2402000A);
        checkOutput("hold1_lanes", id_inst1, 64'h00000000_2402000A);
        tick();
        tick();
        checkOutput("hold3_inst", id_inst0, 64'h2402000A);
        checkOutput("hold3_pc", id_pc0, 64'h100);
        checkOutput("hold3_stall_cnt", stall_cnt0, 64'd3);
        checkOutput("hold3_bubble_cnt", bubble_cnt0, 64'd0);
        checkOutput("hold3_narrow_cnt", stall_cnt1, 64'd3);
        checkOutput("hold3_inst_reg", id_inst2, 64'h2402000A);

        applyStimulus(32'h104, 32'hDEADBEEF, 1'b1, {32'h8C430004, 32'hDEADBEEF}, 2'b11, 6'b000000, 1'b0);
        tick();
        checkOutput("rel_pc", id_pc0, 64'h104);
        checkOutput("rel_inst", id_inst0, 64'hDEADBEEF);
        checkOutput("rel_stall_cnt", stall_cnt0, 64'd3);
        checkOutput("rel_lanes", id_inst1, 64'h8C430004_DEADBEEF);
        checkOutput("rel_inst_reg", id_inst2, 64'hDEADBEEF);

        $display("[TB] bubble");
        applyStimulus(32'h108, 32'h11111111, 1'b1, {32'h8C430004, 32'h11111111}, 2'b11, 6'b000010, 1'b0);
        tick();
        checkOutput("bub_valid", id_valid0, 64'h0);
        checkOutput("bub_pc", id_pc0, 64'h0);
        checkOutput("bub_inst", id_inst0, 64'h0);
        checkOutput("bub_cnt", bubble_cnt0, 64'd1);
        checkOutput("bub_inst_reg", id_inst2, 64'h0);

        applyStimulus(32'h108, 32'h11111111, 1'b1, {32'h8C430004, 32'h11111111}, 2'b11, 6'b000000, 1'b0);
        tick();
        checkOutput("adv2_pc", id_pc0, 64'h108);
        checkOutput("adv2_inst", id_inst0, 64'h11111111);

        $display("[TB] flush during hold");
        applyStimulus(32'h10C, 32'h11111111, 1'b1, {32'h8C430004, 32'h11111111}, 2'b11, 6'b000110, 1'b0);
        tick();
        checkOutput("hold4_stall_cnt", stall_cnt0, 64'd4);
        checkOutput("narrow_stall_sat", stall_cnt1, 64'd3);
        applyStimulus(32'h10C, 32'h22222222, 1'b1, {32'h8C430004, 32'h22222222}, 2'b11, 6'b000110, 1'b1);
        checkOutput("hold4_inst", id_inst0, 64'h11111111);
        tick();
        checkOutput("fl_valid", id_valid0, 64'h0);
        checkOutput("fl_pc", id_pc0, 64'h0);
        checkOutput("fl_inst", id_inst0, 64'h0);
        checkOutput("fl_bubble_cnt", bubble_cnt0, 64'd2);
        checkOutput("fl_stall_cnt", stall_cnt0, 64'd4);

        applyStimulus(32'h10C, 32'h33333333, 1'b1, {32'h8C430004, 32'h33333333}, 2'b11, 6'b000000, 1'b0);
        tick();
        checkOutput("postfl_inst", id_inst0, 64'h33333333);
        checkOutput("postfl_pc", id_pc0, 64'h10C);
        checkOutput("postfl_inst_reg", id_inst2, 64'h33333333);

        $display("[TB] counter saturation");
        applyStimulus(32'h110, 32'h33333333, 1'b1, {32'h8C430004, 32'h33333333}, 2'b11, 6'b000010, 1'b0);
        tick();
        tick();
        checkOutput("bub_cnt4", bubble_cnt0, 64'd4);
        checkOutput("narrow_bub_sat", bubble_cnt1, 64'd3);

        $display("[TB] reset mid-hold");
        applyStimulus(32'h110, 32'h44444444, 1'b1, {32'h8C430004, 32'h44444444}, 2'b11, 6'b000110, 1'b0);
        tick();
        checkOutput("pre_rst_stall_cnt", stall_cnt0, 64'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(32'h110, 32'h44444444, 1'b1, {32'h8C430004, 32'h44444444}, 2'b11, 6'b000000, 1'b0);
        checkOutput("rst2_valid", id_valid0, 64'h0);
        checkOutput("rst2_inst", id_inst0, 64'h0);
        checkOutput("rst2_stall_cnt", stall_cnt0, 64'h0);
        checkOutput("rst2_bubble_cnt", bubble_cnt0, 64'h0);
        checkOutput("rst2_narrow_cnt", bubble_cnt1, 64'h0);
        tick();
        checkOutput("rst2_adv_pc", id_pc0, 64'h110);
        checkOutput("rst2_adv_inst", id_inst0, 64'h44444444);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
